csr_access_ctrl: RTL and testbench

- Sequences all read-modify-write traffic into the single-port CSR register file (WE/A/RD/WD: combinational read, synchronous write).
- Arbitrates between two requesters: the core CSR-instruction unit and the debug module.
- Implements the Zicsr semantics CSRRW/RS/RC and their immediate forms, plus privilege and read-only checks.
- Sits between the execute stage, the debug module and the CSR file.

---
 rtl/csr_access_pkg.sv | 37 +++
 rtl/csr_access_ctrl_if.sv | 52 +++++
 rtl/csr_rr_arb.sv | 33 +++
 rtl/csr_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_pkg.sv
// Shared types and constants for the CSR access controller.
// Optional mcycle counter: define CSR_ACCESS_MCYCLE_EN.
package csr_access_pkg;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [11:0] CSR_MCYCLE = 12'hB00;
    localparam logic [11:0] CSR_CYCLE  = 12'hC00;

    function automatic logic op_legal(logic [2:0] op);
        return op inside {OP_RW, OP_RS, OP_RC,
                          OP_RWI, OP_RSI, OP_RCI};
    endfunction

    function automatic logic is_counter(logic [11:0] a);
        return (a == CSR_MCYCLE) || (a == CSR_CYCLE);
    endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request/response channels of the core CSR unit and the debug module.
// master = requester side, slave = csr_access_ctrl.
interface csr_access_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 12
);
    logic              core_valid;
    logic              core_ready;
    logic [2:0]        core_op;
    logic [ADDR_W-1:0] core_addr;
    logic [XLEN-1:0]   core_wdata;
    logic              core_src_x0;
    logic [1:0]        core_priv;
    logic              core_rvalid;
    logic              core_rready;
    logic [XLEN-1:0]   core_rdata;
    logic              core_illegal;

    logic              dbg_valid;
    logic              dbg_ready;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_wdata;
    logic              dbg_rvalid;
    logic              dbg_rready;
    logic [XLEN-1:0]   dbg_rdata;
    logic              dbg_err;

    modport master (
        output core_valid, core_op, core_addr,
        output core_wdata, core_src_x0, core_priv,
        output core_rready,
        input  core_ready, core_rvalid,
        input  core_rdata, core_illegal,
        output dbg_valid, dbg_we, dbg_addr,
        output dbg_wdata, dbg_rready,
        input  dbg_ready, dbg_rvalid,
        input  dbg_rdata, dbg_err
    );

    modport slave (
        input  core_valid, core_op, core_addr,
        input  core_wdata, core_src_x0, core_priv,
        input  core_rready,
        output core_ready, core_rvalid,
        output core_rdata, core_illegal,
        input  dbg_valid, dbg_we, dbg_addr,
        input  dbg_wdata, dbg_rready,
        output dbg_ready, dbg_rvalid,
        output dbg_rdata, dbg_err
    );
endinterface

// File: rtl/csr_rr_arb.sv
// 2-way round-robin arbiter; bit 0 = core, bit 1 = debug.
// Grants are combinational; the pointer flips to the other side on a grant.
module csr_rr_arb
    import csr_access_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio_dbg;

    // grant at most one requester; pointer breaks ties
    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            !en:                   gnt = 2'b00;
            en && req == 2'b11:    gnt = prio_dbg ? 2'b10 : 2'b01;
            default:               gnt = req;
        endcase
    end

    // the side just served loses priority next time
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            prio_dbg <= 1'b0;
        else if (gnt[0])
            prio_dbg <= 1'b1;
        else if (gnt[1])
            prio_dbg <= 1'b0;
    end
endmodule

// File: rtl/csr_access_ctrl.sv
// Read-modify-write sequencer for the single-port CSR file (core + debug).
// Optional mcycle counter at 0xB00/0xC00: define CSR_ACCESS_MCYCLE_EN.
module csr_access_ctrl
    import csr_access_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    csr_access_ctrl_if.slave  bus,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_a,
    output logic [XLEN-1:0]   csr_wd,
    input  logic [XLEN-1:0]   csr_rd
);
    state_e            state;
    logic              owner_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              x0_q;
    logic              dwe_q;
    logic [1:0]        priv_q;
    logic [XLEN-1:0]   resp_q;
    logic [XLEN-1:0]   nv_q;
    logic              ill_q;
    logic              core_rv_q;
    logic              dbg_rv_q;
    logic              we_q;
    logic [ADDR_W-1:0] a_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic              sel_file;
    logic              to_file;
    logic [XLEN-1:0]   old;
    logic [XLEN-1:0]   newv;
    logic              wr_int;
    logic              ill;

    assign req    = {bus.dbg_valid, bus.core_valid};
    assign arb_en = (state == IDLE);

    csr_rr_arb u_arb (
        .CLK  (CLK),
        .RSTn (RSTn),
        .en   (arb_en),
        .req  (req),
        .gnt  (gnt)
    );

    assign bus.core_ready = gnt[0];
    assign bus.dbg_ready  = gnt[1];

    assign sel_addr  = gnt[1] ? bus.dbg_addr  : bus.core_addr;
    assign sel_wdata = gnt[1] ? bus.dbg_wdata : bus.core_wdata;

`ifdef CSR_ACCESS_MCYCLE_EN
    logic [63:0] mcycle_q;

    assign sel_file = !is_counter(sel_addr);
    assign to_file  = !is_counter(addr_q);
    assign old      = is_counter(addr_q) ? XLEN'(mcycle_q) : csr_rd;

    // free-running counter; a legal write to mcycle wins over the increment
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            mcycle_q <= '0;
        else if (state == WRITE && addr_q == CSR_MCYCLE)
            mcycle_q <= 64'(nv_q);
        else
            mcycle_q <= mcycle_q + 64'd1;
    end
`else
    assign sel_file = 1'b1;
    assign to_file  = 1'b1;
    assign old      = csr_rd;
`endif

    // write intent, legality and the modified value for the READ cycle
    always_comb begin
        wr_int = owner_q ? dwe_q : (op_q[1:0] == 2'b01 || !x0_q);
        ill    = 1'b0;
        if (addr_q[11:10] == 2'b11 && wr_int)
            ill = 1'b1;
        if (!owner_q && priv_q < addr_q[9:8])
            ill = 1'b1;
        if (!owner_q && !op_legal(op_q))
            ill = 1'b1;
        newv = wdata_q;
        unique case (1'b1)
            owner_q:
                newv = wdata_q;
            !owner_q && op_q[1:0] == 2'b10:
                newv = old | wdata_q;
            !owner_q && op_q[1:0] == 2'b11:
                newv = old & ~wdata_q;
            default:
                newv = wdata_q;
        endcase
    end

    // main sequencer: IDLE -> READ -> [WRITE] -> RESP
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            owner_q   <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            x0_q      <= 1'b0;
            dwe_q     <= 1'b0;
            priv_q    <= '0;
            resp_q    <= '0;
            nv_q      <= '0;
            ill_q     <= 1'b0;
            core_rv_q <= 1'b0;
            dbg_rv_q  <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        owner_q <= gnt[1];
                        op_q    <= bus.core_op;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        x0_q    <= bus.core_src_x0;
                        dwe_q   <= bus.dbg_we;
                        priv_q  <= bus.core_priv;
                        a_q     <= sel_file ? sel_addr : '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    resp_q <= ill ? '0 : old;
                    ill_q  <= ill;
                    nv_q   <= newv;
                    if (wr_int && !ill) begin
                        we_q  <= to_file;
                        state <= WRITE;
                    end else begin
                        a_q       <= '0;
                        core_rv_q <= !owner_q;
                        dbg_rv_q  <= owner_q;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    we_q      <= 1'b0;
                    a_q       <= '0;
                    core_rv_q <= !owner_q;
                    dbg_rv_q  <= owner_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (owner_q ? bus.dbg_rready : bus.core_rready) begin
                        core_rv_q <= 1'b0;
                        dbg_rv_q  <= 1'b0;
                        ill_q     <= 1'b0;
                        resp_q    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign csr_we = we_q;
    assign csr_a  = a_q;
    assign csr_wd = we_q ? nv_q : '0;

    assign bus.core_rvalid  = core_rv_q;
    assign bus.core_rdata   = core_rv_q ? resp_q : '0;
    assign bus.core_illegal = core_rv_q & ill_q;
    assign bus.dbg_rvalid   = dbg_rv_q;
    assign bus.dbg_rdata    = dbg_rv_q ? resp_q : '0;
    assign bus.dbg_err      = dbg_rv_q & ill_q;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl with a behavioural CSR file.
// Build with CSR_ACCESS_MCYCLE_EN to exercise the mcycle counter.
module tb_csr_access_ctrl;
    import csr_access_pkg::*;

    localparam int XLEN = 64;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic clr = 1'b1;
    logic csr_we;
    logic [11:0] csr_a;
    logic [XLEN-1:0] csr_wd;
    logic [XLEN-1:0] csr_rd;
    logic [XLEN-1:0] mem [0:4095];

    csr_access_ctrl_if #(.XLEN(XLEN), .ADDR_W(12)) bus();

    csr_access_ctrl #(.XLEN(XLEN), .ADDR_W(12)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .bus    (bus),
        .csr_we (csr_we),
        .csr_a  (csr_a),
        .csr_wd (csr_wd),
        .csr_rd (csr_rd)
    );

    initial forever #5 CLK = ~CLK;

    // CSR file model: combinational read, synchronous write
    always @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (csr_we) begin
            mem[csr_a] <= csr_wd;
        end
    end
    assign csr_rd = mem[csr_a];

    typedef struct {
        logic [63:0] data;
        logic        ill;
        int          lat;
        bit          dc;
        bit          rng;
    } exp_t;

    typedef struct {
        logic [11:0] a;
        logic [63:0] d;
    } wr_t;

    exp_t cq[$];
    exp_t dq[$];
    wr_t  wq[$];
    bit   glog[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_c = 0;
    int   hs_d = 0;
    bit   seen_c = 0;
    bit   seen_d = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic resp(input bit own, input logic [63:0] rd,
                        input logic il, input int lat);
        exp_t  e;
        string p;
        int    n;
        p = own ? "dbg" : "core";
        n = own ? dq.size() : cq.size();
        if (n == 0) begin
            vectors++;
            errors++;
            $display("FAIL %s_unexpected_rvalid: got rdata 0x%0h want none",
                     p, rd);
        end else begin
            if (own) e = dq.pop_front();
            else     e = cq.pop_front();
            if (e.rng) begin
                vectors++;
                if (rd < e.data || rd > e.data + 64'd95) begin
                    errors++;
                    $display("FAIL %s_rdata_range: got %0d want %0d..%0d",
                             p, rd, e.data, e.data + 64'd95);
                end
            end else if (!e.dc) begin
                chk({p, "_rdata"}, rd, e.data);
            end
            chk({p, "_illegal"}, 64'(il), 64'(e.ill));
            chk({p, "_latency"}, 64'(lat), 64'(e.lat));
        end
    endtask

    // monitor: handshakes, CSR-file writes and responses
    initial begin
        wr_t w;
        forever begin
            @(negedge CLK);
            if (bus.core_valid && bus.core_ready) begin
                hs_c = cyc + 1;
                glog.push_back(1'b0);
            end
            if (bus.dbg_valid && bus.dbg_ready) begin
                hs_d = cyc + 1;
                glog.push_back(1'b1);
            end
            if (csr_we) begin
                if (wq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL csr_we_unexpected: got a=0x%0h wd=0x%0h want no write",
                             csr_a, csr_wd);
                end else begin
                    w = wq.pop_front();
                    chk("csr_a", 64'(csr_a), 64'(w.a));
                    chk("csr_wd", csr_wd, w.d);
                end
            end
            if (bus.core_rvalid) begin
                if (!seen_c)
                    resp(1'b0, bus.core_rdata, bus.core_illegal, cyc - hs_c);
                seen_c = !bus.core_rready;
            end else begin
                seen_c = 1'b0;
            end
            if (bus.dbg_rvalid) begin
                if (!seen_d)
                    resp(1'b1, bus.dbg_rdata, bus.dbg_err, cyc - hs_d);
                seen_d = !bus.dbg_rready;
            end else begin
                seen_d = 1'b0;
            end
        end
    end

    task automatic core_req(
        input logic [2:0] op, input logic [11:0] a,
        input logic [63:0] wd, input bit x0, input logic [1:0] pr,
        input bit push, input logic [63:0] ed, input bit il,
        input bit lat2, input bit fw, input logic [63:0] fwd,
        input bit dc, input bit rng);
        bit got;
        exp_t e;
        wr_t w;
        if (push) begin
            e = '{ed, il, lat2 ? 2 : 1, dc, rng};
            cq.push_back(e);
            if (fw) begin
                w = '{a, fwd};
                wq.push_back(w);
            end
        end
        @(posedge CLK);
        #1;
        bus.core_op     = op;
        bus.core_addr   = a;
        bus.core_wdata  = wd;
        bus.core_src_x0 = x0;
        bus.core_priv   = pr;
        bus.core_valid  = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (bus.core_ready) got = 1;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL core_grant_timeout: got no core_ready want grant");
        end
        @(posedge CLK);
        #1;
        bus.core_valid = 1'b0;
    endtask

    task automatic dbg_req(
        input bit we, input logic [11:0] a, input logic [63:0] wd,
        input logic [63:0] ed, input bit er, input bit lat2,
        input bit fw);
        bit got;
        exp_t e;
        wr_t w;
        e = '{ed, er, lat2 ? 2 : 1, 1'b0, 1'b0};
        dq.push_back(e);
        if (fw) begin
            w = '{a, wd};
            wq.push_back(w);
        end
        @(posedge CLK);
        #1;
        bus.dbg_we    = we;
        bus.dbg_addr  = a;
        bus.dbg_wdata = wd;
        bus.dbg_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (bus.dbg_ready) got = 1;
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL dbg_grant_timeout: got no dbg_ready want grant");
        end
        @(posedge CLK);
        #1;
        bus.dbg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (cq.size() == 0 && dq.size() == 0 && wq.size() == 0)
                done = 1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL response_timeout: got %0d/%0d/%0d pending want 0",
                     cq.size(), dq.size(), wq.size());
            cq.delete();
            dq.delete();
            wq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.core_valid  = 1'b0;
        bus.core_op     = '0;
        bus.core_addr   = '0;
        bus.core_wdata  = '0;
        bus.core_src_x0 = 1'b0;
        bus.core_priv   = '0;
        bus.core_rready = 1'b1;
        bus.dbg_valid   = 1'b0;
        bus.dbg_we      = 1'b0;
        bus.dbg_addr    = '0;
        bus.dbg_wdata   = '0;
        bus.dbg_rready  = 1'b1;

        repeat (3) @(negedge CLK);
        chk("rst_csr_we", 64'(csr_we), 64'd0);
        chk("rst_csr_a", 64'(csr_a), 64'd0);
        chk("rst_csr_wd", csr_wd, 64'd0);
        chk("rst_core_rvalid", 64'(bus.core_rvalid), 64'd0);
        chk("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        chk("rst_core_rdata", bus.core_rdata, 64'd0);
        clr  = 1'b0;
        RSTn = 1'b1;
        @(negedge CLK);

        // simultaneous requesters from reset: core first, then alternate
        glog.delete();
        fork
            begin
                core_req(OP_RS, 12'h340, 64'h0, 1, 2'd3,
                         1, 64'h0, 0, 0, 0, 64'h0, 0, 0);
                core_req(OP_RS, 12'h341, 64'h0, 1, 2'd3,
                         1, 64'h0, 0, 0, 0, 64'h0, 0, 0);
            end
            begin
                dbg_req(0, 12'h7B0, 64'h0, 64'h0, 0, 0, 0);
                dbg_req(0, 12'h7B1, 64'h0, 64'h0, 0, 0, 0);
            end
        join
        wait_idle();
        chk("arb_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            chk("arb_g0", 64'(glog[0]), 64'd0);
            chk("arb_g1", 64'(glog[1]), 64'd1);
            chk("arb_g2", 64'(glog[2]), 64'd0);
            chk("arb_g3", 64'(glog[3]), 64'd1);
        end

        dbg_req(1, 12'h340, 64'h0F, 64'h0, 0, 1, 1);
        wait_idle();
        core_req(OP_RS, 12'h340, 64'hF0, 0, 2'd3,
                 1, 64'h0F, 0, 1, 1, 64'hFF, 0, 0);
        wait_idle();
        core_req(OP_RC, 12'h340, 64'h0F, 1, 2'd3,
                 1, 64'hFF, 0, 0, 0, 64'h0, 0, 0);
        wait_idle();
        core_req(OP_RW, 12'hF14, 64'h5, 0, 2'd3,
                 1, 64'h0, 1, 0, 0, 64'h0, 0, 0);
        wait_idle();
        dbg_req(1, 12'h300, 64'hAA, 64'h0, 0, 1, 1);
        wait_idle();
        core_req(OP_RS, 12'h300, 64'h1, 0, 2'd0,
                 1, 64'h0, 1, 0, 0, 64'h0, 0, 0);
        wait_idle();
        core_req(OP_RS, 12'h300, 64'h0, 1, 2'd0,
                 1, 64'h0, 1, 0, 0, 64'h0, 0, 0);
        wait_idle();
        dbg_req(0, 12'h300, 64'h0, 64'hAA, 0, 0, 0);
        wait_idle();
        dbg_req(1, 12'hF14, 64'h9, 64'h0, 1, 0, 0);
        wait_idle();
        core_req(OP_RS, 12'h340, 64'h0, 1, 2'd1,
                 1, 64'h0, 1, 0, 0, 64'h0, 0, 0);
        wait_idle();
        core_req(OP_RW, 12'h100, 64'h7, 0, 2'd1,
                 1, 64'h0, 0, 1, 1, 64'h7, 0, 0);
        wait_idle();
        core_req(OP_RW, 12'h001, 64'h3, 0, 2'd0,
                 1, 64'h0, 0, 1, 1, 64'h3, 0, 0);
        wait_idle();
        core_req(OP_RWI, 12'h340, 64'h15, 0, 2'd3,
                 1, 64'hFF, 0, 1, 1, 64'h15, 0, 0);
        wait_idle();
        core_req(OP_RSI, 12'h340, 64'h0, 1, 2'd3,
                 1, 64'h15, 0, 0, 0, 64'h0, 0, 0);
        wait_idle();
        core_req(OP_RCI, 12'h340, 64'h5, 0, 2'd3,
                 1, 64'h15, 0, 1, 1, 64'h10, 0, 0);
        wait_idle();

        // reset while the write strobe is up: nothing lands, no response
        core_req(OP_RW, 12'h340, 64'h77, 0, 2'd3,
                 0, 64'h0, 0, 0, 0, 64'h0, 0, 0);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 10 && !hit; i++) begin
                if (csr_we) hit = 1;
                else begin
                    @(posedge CLK);
                    #1;
                end
            end
            chk("rst_mid_saw_we", 64'(hit), 64'd1);
        end
        RSTn = 1'b0;
        #1;
        chk("rst_mid_csr_we", 64'(csr_we), 64'd0);
        chk("rst_mid_csr_a", 64'(csr_a), 64'd0);
        chk("rst_mid_rvalid", 64'(bus.core_rvalid), 64'd0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        core_req(OP_RS, 12'h340, 64'h0, 1, 2'd3,
                 1, 64'h10, 0, 0, 0, 64'h0, 0, 0);
        wait_idle();

`ifdef CSR_ACCESS_MCYCLE_EN
        core_req(OP_RW, 12'hB00, 64'd100, 0, 2'd3,
                 1, 64'h0, 0, 1, 0, 64'h0, 1, 0);
        repeat (5) @(posedge CLK);
        core_req(OP_RS, 12'hC00, 64'h0, 1, 2'd0,
                 1, 64'd105, 0, 0, 0, 64'h0, 0, 1);
        wait_idle();
        core_req(OP_RW, 12'hC00, 64'h1, 0, 2'd3,
                 1, 64'h0, 1, 0, 0, 64'h0, 0, 0);
        wait_idle();
`else
        core_req(OP_RW, 12'hB00, 64'd100, 0, 2'd3,
                 1, 64'h0, 0, 1, 1, 64'd100, 0, 0);
        wait_idle();
        core_req(OP_RS, 12'hB00, 64'h0, 1, 2'd3,
                 1, 64'd100, 0, 0, 0, 64'h0, 0, 0);
        wait_idle();
`endif

        chk("writes_left", 64'(wq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
